// File: rtl/ysyx_23060201_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between IFU fetches and LSU loads/stores.
// One transaction in flight; the response is held until the owning requester accepts it.
module ysyx_23060201_mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_raddr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_req_wen,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [7:0]            lsu_mask,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [7:0]            mem_rmask,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [7:0]            mem_wmask
);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state;
    logic             last_lsu;
    logic             owner_lsu;
    logic             is_write;
    logic [CNT_W-1:0] cnt;
    logic             grant_ifu;
    logic             grant_lsu;

    // Ready is gated by rst_n so no handshake can be reported while reset is held.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (rst_n && state == IDLE) begin
            if (ifu_req_valid && (!lsu_req_valid || last_lsu)) begin
                grant_ifu = 1'b1;
            end else if (lsu_req_valid) begin
                grant_lsu = 1'b1;
            end
        end
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_lsu       <= 1'b1;
            owner_lsu      <= 1'b0;
            is_write       <= 1'b0;
            cnt            <= '0;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            lsu_rdata      <= '0;
            mem_ren        <= 1'b0;
            mem_raddr      <= '0;
            mem_rmask      <= '0;
            mem_wen        <= 1'b0;
            mem_waddr      <= '0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ifu || grant_lsu) begin
                        owner_lsu <= grant_lsu;
                        last_lsu  <= grant_lsu;
                        cnt       <= CNT_W'(MEM_LATENCY - 1);
                        state     <= ACCESS;
                        if (grant_lsu && lsu_req_wen) begin
                            is_write  <= 1'b1;
                            mem_wen   <= 1'b1;
                            mem_waddr <= lsu_addr;
                            mem_wdata <= lsu_wdata;
                            mem_wmask <= lsu_mask;
                        end else begin
                            is_write  <= 1'b0;
                            mem_ren   <= 1'b1;
                            mem_raddr <= grant_lsu ? lsu_addr : ifu_raddr;
                            mem_rmask <= grant_lsu ? lsu_mask : 8'h0F;
                        end
                    end
                end
                ACCESS: begin
                    // A store pulses mem_wen only in the first ACCESS cycle.
                    mem_wen <= 1'b0;
                    if (cnt == '0) begin
                        mem_ren <= 1'b0;
                        state   <= RESP;
                        if (owner_lsu) begin
                            lsu_rdata      <= is_write ? '0 : mem_rdata;
                            lsu_resp_valid <= 1'b1;
                        end else begin
                            ifu_rdata      <= mem_rdata;
                            ifu_resp_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (owner_lsu ? lsu_resp_ready : ifu_resp_ready) begin
                        ifu_resp_valid <= 1'b0;
                        lsu_resp_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Bench for the memory arbiter: directed scenarios plus random traffic checked against a
// transaction/timing model (handshake edge + latency arithmetic) and a word-array memory.
module tb_ysyx_23060201_mem_arbiter;
    localparam int ML = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1'b0;
    logic [31:0] ifu_raddr = '0, ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_req_wen = 1'b0;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
    logic [7:0]  lsu_mask = '0;
    logic        lsu_resp_valid, lsu_resp_ready = 1'b0;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic [7:0]  mem_rmask, mem_wmask;

    ysyx_23060201_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_raddr(ifu_raddr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_mask(lsu_mask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rmask(mem_rmask), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
    );

    always #5 clk = ~clk;

    // environment memory (driven by the DUT) and reference memory (driven by the model)
    logic [31:0] env_mem [16];
    logic [31:0] ref_mem [16];
    always_comb mem_rdata = env_mem[mem_raddr[5:2]];

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // requester intents
    logic        ifu_pend = 0, ifu_rr = 0;
    logic [31:0] ifu_pend_addr = '0;
    logic        lsu_pend = 0, lsu_rr = 0, lsu_pend_wen = 0;
    logic [31:0] lsu_pend_addr = '0, lsu_pend_wdata = '0;
    logic [7:0]  lsu_pend_mask = '0;
    logic        rand_mode = 0, auto_rearm = 0;

    // transaction model
    int          cyc = 0;
    logic        live = 0, m_owner_lsu = 0, m_wr = 0, m_last_lsu = 1;
    int          t_hs = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_ifu_rdata = '0, m_lsu_rdata = '0;
    logic [7:0]  m_mask = '0;

    // observation bookkeeping
    int   wen_cnt = 0, ren_cnt = 0;
    int   ifu_hs_edge = -1, lsu_hs_edge = -1, lsu_rel_edge = -1;
    int   ifu_resp_cyc = -1, lsu_resp_cyc = -1;
    logic prev_ifu_rv = 0, prev_lsu_rv = 0;
    bit   glog[$];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [7:0] m);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic reset_model();
        live = 0; m_last_lsu = 1; m_ifu_rdata = '0; m_lsu_rdata = '0;
        ifu_pend = 0; lsu_pend = 0; prev_ifu_rv = 0; prev_lsu_rv = 0;
    endtask

    task automatic tick();
        logic ren_exp, wen_exp, resp_exp, g_ifu, g_lsu;
        @(negedge clk);
        if (mem_wen) begin
            wen_cnt++;
            env_mem[mem_waddr[5:2]] = merge(env_mem[mem_waddr[5:2]], mem_wdata, mem_wmask);
        end
        if (mem_ren) ren_cnt++;
        if (ifu_resp_valid && !prev_ifu_rv) ifu_resp_cyc = cyc;
        if (lsu_resp_valid && !prev_lsu_rv) lsu_resp_cyc = cyc;
        prev_ifu_rv = ifu_resp_valid;
        prev_lsu_rv = lsu_resp_valid;

        ren_exp  = live && !m_wr && cyc >= t_hs && cyc < t_hs + ML;
        wen_exp  = live && m_wr && cyc == t_hs;
        resp_exp = live && cyc >= t_hs + ML;
        check_val("mem_ren", mem_ren, ren_exp);
        check_val("mem_wen", mem_wen, wen_exp);
        check_val("ifu_resp_valid", ifu_resp_valid, resp_exp && !m_owner_lsu);
        check_val("lsu_resp_valid", lsu_resp_valid, resp_exp && m_owner_lsu);
        check_val("ifu_rdata", ifu_rdata, m_ifu_rdata);
        check_val("lsu_rdata", lsu_rdata, m_lsu_rdata);
        if (ren_exp) begin
            check_val("mem_raddr", mem_raddr, m_addr);
            check_val("mem_rmask", mem_rmask, m_mask);
        end
        if (wen_exp) begin
            check_val("mem_waddr", mem_waddr, m_addr);
            check_val("mem_wdata", mem_wdata, m_wdata);
            check_val("mem_wmask", mem_wmask, m_mask);
        end

        if (rand_mode) begin
            if (!ifu_pend && $urandom_range(0, 2) == 0) begin
                ifu_pend = 1; ifu_pend_addr = $urandom;
            end
            if (!lsu_pend && $urandom_range(0, 2) == 0) begin
                lsu_pend = 1; lsu_pend_addr = $urandom; lsu_pend_wdata = $urandom;
                lsu_pend_wen = $urandom_range(0, 1) == 1;
                lsu_pend_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            end
            ifu_rr = $urandom_range(0, 1) == 1;
            lsu_rr = $urandom_range(0, 1) == 1;
        end
        ifu_req_valid = ifu_pend; ifu_raddr = ifu_pend_addr;
        lsu_req_valid = lsu_pend; lsu_addr = lsu_pend_addr; lsu_wdata = lsu_pend_wdata;
        lsu_req_wen = lsu_pend_wen; lsu_mask = lsu_pend_mask;
        ifu_resp_ready = ifu_rr; lsu_resp_ready = lsu_rr;
        #1;
        // round robin: a tie goes to whoever was not granted last
        g_ifu = !live && ifu_pend && (!lsu_pend || m_last_lsu);
        g_lsu = !live && lsu_pend && !g_ifu;
        check_val("ifu_req_ready", ifu_req_ready, g_ifu);
        check_val("lsu_req_ready", lsu_req_ready, g_lsu);

        if (live) begin
            if (resp_exp && (m_owner_lsu ? lsu_rr : ifu_rr)) begin
                live = 0;
                if (m_owner_lsu) lsu_rel_edge = cyc + 1;
            end else if (cyc == t_hs + ML - 1) begin
                if (m_owner_lsu) m_lsu_rdata = m_wr ? 32'h0 : ref_mem[m_addr[5:2]];
                else m_ifu_rdata = ref_mem[m_addr[5:2]];
            end
        end else if (g_ifu || g_lsu) begin
            live = 1; t_hs = cyc + 1; m_owner_lsu = g_lsu; m_last_lsu = g_lsu;
            m_wr = g_lsu && lsu_pend_wen;
            m_addr = g_lsu ? lsu_pend_addr : ifu_pend_addr;
            m_mask = g_lsu ? lsu_pend_mask : 8'h0F;
            m_wdata = lsu_pend_wdata;
            if (m_wr) ref_mem[m_addr[5:2]] = merge(ref_mem[m_addr[5:2]], m_wdata, m_mask);
            glog.push_back(g_lsu);
            if (g_lsu) begin
                lsu_hs_edge = cyc + 1; lsu_pend = auto_rearm;
                if (auto_rearm) lsu_pend_addr = $urandom;
            end else begin
                ifu_hs_edge = cyc + 1; ifu_pend = auto_rearm;
                if (auto_rearm) ifu_pend_addr = $urandom;
            end
        end
        cyc++;
    endtask

    task automatic run_idle(input string tag, input int budget);
        int i = 0;
        while (i < budget && (live || ifu_pend || lsu_pend)) begin
            tick(); i++;
        end
        check_val(tag, live || ifu_pend || lsu_pend, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid}, 0);
        check_val({tag, "_en"}, {mem_ren, mem_wen}, 0);
        check_val({tag, "_addr"}, {mem_raddr, mem_waddr}, 0);
        check_val({tag, "_data"}, {mem_wdata, mem_rmask, mem_wmask}, 0);
        check_val({tag, "_rdata"}, {ifu_rdata, lsu_rdata}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 16; i++) begin
            v = $urandom; env_mem[i] = v; ref_mem[i] = v;
        end
        ifu_req_valid = 1;
        lsu_req_valid = 1;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        ifu_req_valid = 0; lsu_req_valid = 0;
        rst_n = 1;

        // IFU fetch alone
        env_mem[0] = 32'h0010_0093; ref_mem[0] = 32'h0010_0093;
        ifu_rr = 1; lsu_rr = 1; ren_cnt = 0;
        ifu_pend = 1; ifu_pend_addr = 32'h8000_0000;
        run_idle("ifu_fetch_done", 30);
        check_val("ifu_ren_cycles", ren_cnt, ML);
        check_val("ifu_latency", ifu_resp_cyc - ifu_hs_edge, ML);
        check_val("ifu_fetch_data", ifu_rdata, 32'h0010_0093);

        // LSU store, then load back
        wen_cnt = 0;
        lsu_pend = 1; lsu_pend_wen = 1; lsu_pend_addr = 32'h8000_1000;
        lsu_pend_wdata = 32'hDEAD_BEEF; lsu_pend_mask = 8'h0F;
        run_idle("store_done", 30);
        check_val("store_wen_pulses", wen_cnt, 1);
        check_val("store_latency", lsu_resp_cyc - lsu_hs_edge, ML);
        check_val("store_rdata", lsu_rdata, 0);
        lsu_pend = 1; lsu_pend_wen = 0;
        run_idle("load_done", 30);
        check_val("load_back", lsu_rdata, 32'hDEAD_BEEF);

        // backpressure on an LSU load with IFU waiting
        lsu_rr = 0;
        lsu_pend = 1; lsu_pend_wen = 0; lsu_pend_addr = 32'h8000_0024; lsu_pend_mask = 8'hFF;
        for (int i = 0; i < 20 && lsu_pend; i++) tick();
        check_val("bp_lsu_granted", lsu_pend, 0);
        ifu_pend = 1; ifu_pend_addr = 32'h8000_0008;
        for (int i = 0; i < 20 && !(live && cyc >= t_hs + ML); i++) tick();
        check_val("bp_resp_reached", live && cyc >= t_hs + ML, 1);
        repeat (5) tick();
        check_val("bp_held_data", lsu_rdata, ref_mem[9]);
        lsu_rr = 1;
        run_idle("bp_done", 30);
        check_val("bp_ifu_next", ifu_hs_edge, lsu_rel_edge + 1);

        // reset while a store is in ACCESS
        lsu_pend = 1; lsu_pend_wen = 1; lsu_pend_addr = 32'h8000_0030;
        lsu_pend_wdata = 32'h1234_5678; lsu_pend_mask = 8'h03;
        for (int i = 0; i < 10 && lsu_pend; i++) tick();
        check_val("rst_store_granted", lsu_pend, 0);
        tick();
        @(posedge clk);
        #2;
        ifu_req_valid = 1; lsu_req_valid = 1;
        rst_n = 0;
        #1 check_reset_outputs("midrst");
        reset_model();
        ifu_req_valid = 0; lsu_req_valid = 0;
        wen_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;

        // both requesters valid continuously: grants alternate, IFU first
        glog.delete();
        auto_rearm = 1;
        ifu_pend = 1; ifu_pend_addr = $urandom;
        lsu_pend = 1; lsu_pend_wen = 0; lsu_pend_addr = $urandom; lsu_pend_mask = 8'h0F;
        for (int i = 0; i < 80 && glog.size() < 4; i++) tick();
        check_val("alt_count", glog.size(), 4);
        if (glog.size() >= 4)
            check_val("alt_order", {glog[0], glog[1], glog[2], glog[3]}, 4'b0101);
        check_val("no_wen_after_rst", wen_cnt, 0);
        auto_rearm = 0;
        ifu_pend = 0; lsu_pend = 0;
        run_idle("alt_drain", 30);

        // random traffic
        rand_mode = 1;
        repeat (2000) tick();
        rand_mode = 0;
        ifu_pend = 0; lsu_pend = 0; ifu_rr = 1; lsu_rr = 1;
        run_idle("rand_drain", 40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
